// File: rtl/fetch_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_reader_if
//  Brief    : Memory-read, redirect and decode-handshake bundle of the fetch reader.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_reader_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19
);
    logic               imem_rd;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    // master: the fetch reader itself
    modport master (
        output imem_rd, imem_addr,
        input  imem_data,
        input  redirect, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    // slave: memory + decode environment around the reader
    modport slave (
        input  imem_rd, imem_addr,
        output imem_data,
        output redirect, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_reader
//  Brief    : Fetch PC sequencer with 1-cycle imem reads and a {pc,instr} FIFO.
//             Optional macro FETCH_WRAP_TRAP_EN: halt at top address instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_reader #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19,
    parameter int DEPTH   = 2
) (
    input  wire            clk,
    input  wire            rst,
`ifdef FETCH_WRAP_TRAP_EN
    output logic           halted,
`endif
    fetch_reader_if.master bus
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
`ifdef FETCH_WRAP_TRAP_EN
    localparam bit c_TRAP_EN = 1'b1;
`else
    localparam bit c_TRAP_EN = 1'b0;
`endif

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_pc_q    [DEPTH];
    logic [INSTR_W-1:0] r_instr_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic               w_credit;
    logic               w_at_top;
    logic               w_halted;
    logic [c_CNT_W:0]   w_occ;

    assign bus.out_valid = !rst && (r_count != '0);
    assign w_pop         = bus.out_valid && bus.out_ready;

    // A same-cycle pop frees a slot, so it counts as credit for a new read.
    assign w_occ    = {1'b0, r_count} + (c_CNT_W+1)'(r_inflight) - (c_CNT_W+1)'(w_pop);
    assign w_credit = w_occ < (c_CNT_W+1)'(DEPTH);
    assign w_issue  = !rst && !bus.redirect && !w_halted && w_credit;
    assign w_at_top = &r_fetch_pc;

    // A redirect squashes the response that lands in its own cycle.
    assign w_push   = r_inflight && !bus.redirect && !rst;

    assign bus.imem_rd   = w_issue;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.out_pc    = bus.out_valid ? r_pc_q[r_rd_ptr]    : '0;
    assign bus.out_instr = bus.out_valid ? r_instr_q[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end
            if (bus.redirect) begin
                r_fetch_pc <= bus.redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue && !(c_TRAP_EN && w_at_top)) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: outputs are masked until an entry is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wr_ptr]    <= r_inflight_pc;
            r_instr_q[r_wr_ptr] <= bus.imem_data;
        end
    end

`ifdef FETCH_WRAP_TRAP_EN
    logic r_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (bus.redirect) begin
            r_halted <= 1'b0;
        end else if (w_issue && w_at_top) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
    assign halted   = r_halted;
`else
    assign w_halted = 1'b0;
`endif

endmodule
`default_nettype wire
